bfusion_operand_packer: RTL and testbench

BFUSION_OPERAND_PACKER -- requirements
Module: bfusion_operand_packer

---
 rtl/bfusion_operand_packer_pkg.sv | 15 +
 rtl/bfusion_operand_packer.sv | 88 ++++++++
 tb/tb_bfusion_operand_packer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/bfusion_operand_packer_pkg.sv
// bfusion_operand_packer_pkg: shared widths, precision modes and FSM states for the operand packer
package bfusion_operand_packer_pkg;
  localparam int BEAT_W = 8;
  localparam int WORD_W = 16;
  typedef enum logic [1:0] {
    MODE_8X8 = 2'b00,
    MODE_4X4 = 2'b01,
    MODE_8X4 = 2'b11
  } mode_e;
  localparam logic [1:0] MODE_BAD = 2'b10;
  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } state_e;
endpackage

// File: rtl/bfusion_operand_packer.sv
// bfusion_operand_packer: packs 8-bit a/w beats into 16-bit MAC operand words by precision mode
//   clk, rst           : clock, synchronous active-high reset
//   cfg_mode           : precision (00 8x8, 01 4x4, 11 8x4, 10 illegal), taken on a vector's first beat
//   in_valid/in_ready  : beat handshake; in_a, in_w, in_last carry the beat
//   out_valid/out_ready: word handshake; out_a, out_w, out_config_aw, out_first, out_last carry the word
//   err_mode           : sticky, set when a vector starts with the illegal mode
module bfusion_operand_packer
  import bfusion_operand_packer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cfg_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_a,
  input  logic [BEAT_W-1:0] in_w,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_a,
  output logic [WORD_W-1:0] out_w,
  output logic [1:0]        out_config_aw,
  output logic              out_first,
  output logic              out_last,
  output logic              err_mode
);
  state_e state, state_d;
  logic [1:0] mode_q, cur_mode;
  logic in_vec, half_first, acc, drop, pair, half_st, emit, word_first;
  logic [BEAT_W-1:0] half_a, half_w;
  logic [WORD_W-1:0] word_a, word_w;
  // a new word can be loaded whenever the output register is free or being drained this cycle
  assign in_ready = !rst && (!out_valid || out_ready);
  always_comb begin
    acc = in_valid && in_ready;
    cur_mode = in_vec ? mode_q : cfg_mode;
    drop = cur_mode == MODE_BAD;
    pair = cur_mode != MODE_8X8;
    half_st = state == HALF;
    emit = acc && !drop && (!pair || half_st || in_last);
    word_first = half_st ? half_first : !in_vec;
    // in pair modes a word closed by a lone b0 (in_last on b0) has its b1 lanes zeroed
    word_a = (pair && half_st) ? {in_a, half_a} : {8'h00, in_a};
    word_w = !pair ? {8'h00, in_w} :
             cur_mode == MODE_4X4 ? (half_st ? {in_w, half_w} : {8'h00, in_w}) :
             (half_st ? {8'h00, in_w[3:0], half_w[3:0]} : {12'h000, in_w[3:0]});
    state_d = !acc ? state : (pair && !drop && !half_st && !in_last) ? HALF : EMPTY;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else state <= state_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_8X8;
      in_vec <= 1'b0;
      half_first <= 1'b0;
      half_a <= '0;
      half_w <= '0;
      out_valid <= 1'b0;
      out_a <= '0;
      out_w <= '0;
      out_config_aw <= 2'b00;
      out_first <= 1'b0;
      out_last <= 1'b0;
      err_mode <= 1'b0;
    end else begin
      if (acc) in_vec <= !in_last;
      if (acc && !in_vec) mode_q <= cfg_mode;
      if (acc && drop) err_mode <= 1'b1;
      if (acc && !half_st) begin
        half_a <= in_a;
        half_w <= in_w;
        half_first <= !in_vec;
      end
      if (emit) begin
        out_valid <= 1'b1;
        out_a <= word_a;
        out_w <= word_w;
        out_config_aw <= cur_mode;
        out_first <= word_first;
        out_last <= in_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bfusion_operand_packer.sv
// tb_bfusion_operand_packer: directed self-checking bench for the operand packer
module tb_bfusion_operand_packer;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] cfg_mode = 2'b00;
  logic in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [7:0] in_a = '0, in_w = '0;
  logic out_valid, out_ready = 1'b1, out_first, out_last, err_mode;
  logic [15:0] out_a, out_w;
  logic [1:0] out_config_aw;
  int total = 0, bad = 0, cyc = 0, last_bc = 0;
  typedef struct {
    logic [15:0] a, w;
    logic [1:0] c;
    logic f, l;
    int xc;
  } wd_t;
  wd_t q[$];
  int bc0;

  bfusion_operand_packer dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_w(in_w), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_w(out_w),
    .out_config_aw(out_config_aw), .out_first(out_first), .out_last(out_last),
    .err_mode(err_mode)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (out_valid && out_ready) q.push_back('{out_a, out_w, out_config_aw, out_first, out_last, cyc + 1});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] w, input logic last, input logic [1:0] m);
    in_valid = 1'b1; in_a = a; in_w = w; in_last = last; cfg_mode = m;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) break;
      if (t == 99) chk("send_timeout", 0, 1);
    end
    last_bc = cyc + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string tag, input int i, input logic [15:0] a, input logic [15:0] w,
                          input logic [1:0] c, input logic f, input logic l);
    chk({tag, "_present"}, q.size() > i, 1);
    if (q.size() > i) begin
      chk({tag, "_aw"}, {q[i].a, q[i].w}, {a, w});
      chk({tag, "_cfl"}, {q[i].c, q[i].f, q[i].l}, {c, f, l});
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_aw", {out_a, out_w}, 0);
    chk("rst_flags", {out_first, out_last, err_mode, out_config_aw}, 0);
    @(posedge clk); #1;

    q.delete();
    send(8'h12, 8'h34, 1'b0, 2'b00);
    bc0 = last_bc;
    send(8'hFF, 8'h80, 1'b1, 2'b00);
    idle(4);
    chk("m00_count", q.size(), 2);
    chk_word("m00_w0", 0, 16'h0012, 16'h0034, 2'b00, 1'b1, 1'b0);
    chk_word("m00_w1", 1, 16'h00FF, 16'h0080, 2'b00, 1'b0, 1'b1);
    if (q.size() == 2) begin
      chk("m00_lat0", q[0].xc - bc0, 1);
      chk("m00_lat1", q[1].xc - last_bc, 1);
    end

    q.delete();
    send(8'h21, 8'h43, 1'b0, 2'b01);
    send(8'h65, 8'h87, 1'b1, 2'b00);
    idle(4);
    chk("m01_count", q.size(), 1);
    chk_word("m01", 0, 16'h6521, 16'h8743, 2'b01, 1'b1, 1'b1);

    q.delete();
    send(8'hAB, 8'hF5, 1'b0, 2'b11);
    send(8'hCD, 8'h3E, 1'b1, 2'b11);
    idle(4);
    chk("m11_count", q.size(), 1);
    chk_word("m11", 0, 16'hCDAB, 16'h00E5, 2'b11, 1'b1, 1'b1);

    q.delete();
    send(8'h01, 8'h02, 1'b0, 2'b01);
    send(8'h03, 8'h04, 1'b0, 2'b01);
    send(8'h05, 8'h06, 1'b1, 2'b01);
    idle(4);
    chk("m01pad_count", q.size(), 2);
    chk_word("m01pad_w0", 0, 16'h0301, 16'h0402, 2'b01, 1'b1, 1'b0);
    chk_word("m01pad_w1", 1, 16'h0005, 16'h0006, 2'b01, 1'b0, 1'b1);

    q.delete();
    out_ready = 1'b0;
    send(8'h11, 8'h22, 1'b0, 2'b00);
    in_valid = 1'b1; in_a = 8'h33; in_w = 8'h44; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", {out_a, out_w}, 32'h0011_0022);
      chk("stall_fl", {out_first, out_last}, 2'b10);
      chk("stall_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'h33, 8'h44, 1'b1, 2'b00);
    idle(4);
    chk("stall_count", q.size(), 2);
    chk_word("stall_w0", 0, 16'h0011, 16'h0022, 2'b00, 1'b1, 1'b0);
    chk_word("stall_w1", 1, 16'h0033, 16'h0044, 2'b00, 1'b0, 1'b1);

    q.delete();
    send(8'hA1, 8'hB1, 1'b0, 2'b10);
    send(8'hA2, 8'hB2, 1'b0, 2'b00);
    send(8'hA3, 8'hB3, 1'b1, 2'b00);
    send(8'h44, 8'h55, 1'b0, 2'b00);
    send(8'h66, 8'h77, 1'b1, 2'b00);
    idle(4);
    chk("bad_err", err_mode, 1);
    chk("bad_count", q.size(), 2);
    chk_word("bad_w0", 0, 16'h0044, 16'h0055, 2'b00, 1'b1, 1'b0);
    chk_word("bad_w1", 1, 16'h0066, 16'h0077, 2'b00, 1'b0, 1'b1);

    q.delete();
    send(8'h99, 8'h88, 1'b0, 2'b01);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst2_in_ready", in_ready, 0);
    rst = 1'b0;
    chk("rst2_err", err_mode, 0);
    send(8'h5A, 8'hA5, 1'b1, 2'b01);
    idle(4);
    chk("rst2_count", q.size(), 1);
    chk_word("rst2", 0, 16'h005A, 16'h00A5, 2'b01, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
